// File: rtl/mersenne_pkg.sv
// Shared types and constants for the Mersenne trial-division lane.
package mersenne_pkg;

    localparam int W          = 32;
    localparam int SQR_CYCLES = 32;
    localparam int LATENCY    = 1058;
    localparam int IDX_W      = $clog2(W);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SQR,
        DBL,
        CHECK,
        DONE
    } state_t;

    // Single conditional subtract. Valid when t < 2n. n == 0 disables the
    // reduction, and the value is simply truncated.
    function automatic logic [W-1:0] mod_reduce(input logic [W:0] t, input logic [W-1:0] n);
        logic [W:0] v;
        v = t;
        if ((n != '0) && (v >= {1'b0, n}))
            v = v - {1'b0, n};
        return v[W-1:0];
    endfunction

endpackage

// File: rtl/mod_mult_serial.sv
// Interleaved shift-add modular multiplier: prod = a*b mod n, one bit of b per cycle, MSB first.
module mod_mult_serial
    import mersenne_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] n,
    output logic         done,
    output logic [W-1:0] prod
);

    // Handshake: a one-cycle start clears the accumulator. The following W
    // cycles each consume one bit of b. done is high during the cycle whose
    // edge completes the last step, and prod is valid from that edge until the
    // next start. a, b and n must stay stable while the multiplier is busy.
    logic             busy;
    logic [IDX_W-1:0] j;
    logic [W-1:0]     acc_dbl;
    logic [W-1:0]     acc_next;

    always_comb begin
        acc_dbl  = mod_reduce({prod, 1'b0}, n);
        acc_next = acc_dbl;
        if (b[j])
            acc_next = mod_reduce({1'b0, acc_dbl} + {1'b0, a}, n);
        done = busy && (j == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            j    <= '0;
            prod <= '0;
        end else if (start) begin
            busy <= 1'b1;
            j    <= IDX_W'(W - 1);
            prod <= '0;
        end else if (busy) begin
            prod <= acc_next;
            j    <= j - 1'b1;
            if (j == '0)
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/mersenne_factoring.sv
// One trial-division lane: computes 2^p mod d by MSB-first square-and-double and flags divisibility of 2^p-1.
module mersenne_factoring
    import mersenne_pkg::*;
(
    input  logic         sys_clk,
    input  logic         sys_rst_n,
    input  logic         start,
    input  logic [W-1:0] p,
    input  logic [W-1:0] d,
    output logic         isPrime,
    output logic         finished,
    output state_t       state_dbg
);

    state_t           state;
    state_t           state_next;
    logic [W-1:0]     p_q;
    logic [W-1:0]     d_q;
    logic [W-1:0]     r;
    logic [IDX_W-1:0] i;
    logic             is_prime;
    logic             mult_start;
    logic             mult_done;
    logic [W-1:0]     mult_prod;
    logic [W-1:0]     r_dbl;
    logic [W-1:0]     one_mod_d;

    // r is held constant through SQR, so the squarer can read it directly.
    mod_mult_serial u_sqr (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .start (mult_start),
        .a     (r),
        .b     (r),
        .n     (d_q),
        .done  (mult_done),
        .prod  (mult_prod)
    );

    always_comb begin
        mult_start = (state == LOAD) || ((state == DBL) && (i != '0));
        r_dbl      = p_q[i] ? mod_reduce({mult_prod, 1'b0}, d_q) : mult_prod;
        one_mod_d  = (d_q == W'(1)) ? '0 : W'(1);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = LOAD;
            LOAD:    state_next = SQR;
            SQR:     if (mult_done) state_next = DBL;
            DBL:     state_next = (i == '0) ? CHECK : SQR;
            CHECK:   state_next = DONE;
            DONE:    if (start) state_next = LOAD;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= IDLE;
            p_q      <= '0;
            d_q      <= '0;
            r        <= '0;
            i        <= '0;
            is_prime <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        p_q <= p;
                        d_q <= d;
                    end
                end
                LOAD: begin
                    r <= one_mod_d;
                    i <= IDX_W'(W - 1);
                end
                DBL: begin
                    r <= r_dbl;
                    if (i != '0)
                        i <= i - 1'b1;
                end
                CHECK: is_prime <= (d_q == '0) || (r != one_mod_d);
                default: ;
            endcase
        end
    end

    assign isPrime   = is_prime;
    assign finished  = (state == DONE);
    assign state_dbg = state;

endmodule

// File: tb/tb_mersenne_factoring.sv
// Bench for mersenne_factoring: vector table, scoreboard queue, and hand-written busy/reset sequences.
module tb_mersenne_factoring;
    import mersenne_pkg::*;

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        start     = 1'b0;
    logic [31:0] p         = '0;
    logic [31:0] d         = '0;
    logic        isPrime;
    logic        finished;
    state_t      state_dbg;

    int checks   = 0;
    int failures = 0;
    logic [0:0] exp_q[$];

    typedef struct {
        logic [31:0] p;
        logic [31:0] d;
        logic        exp;
    } vec_t;

    vec_t vecs[12];

    always #5 sys_clk = ~sys_clk;

    mersenne_factoring dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .start     (start),
        .p         (p),
        .d         (d),
        .isPrime   (isPrime),
        .finished  (finished),
        .state_dbg (state_dbg)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference: 2^p mod d by 64-bit arithmetic.
    function automatic logic model(input logic [31:0] pv, input logic [31:0] dv);
        longint unsigned r;
        longint unsigned dd;
        if (dv == 0) return 1'b1;
        dd = longint'(dv);
        r  = 1 % dd;
        for (int k = 31; k >= 0; k--) begin
            r = (r * r) % dd;
            if (pv[k]) r = (r * 2) % dd;
        end
        return r != (1 % dd);
    endfunction

    // Drives a one-cycle start, then scrambles p/d to show they were captured.
    task automatic launch(input logic [31:0] pv, input logic [31:0] dv, input logic e);
        @(negedge sys_clk);
        p     = pv;
        d     = dv;
        start = 1'b1;
        exp_q.push_back(e);
        @(negedge sys_clk);
        start = 1'b0;
        p     = $urandom;
        d     = $urandom;
    endtask

    // Counts edges after the start-sampling edge; optional stray start at inj_cycle.
    task automatic wait_done(input string name, input int inj_cycle);
        int   cnt;
        logic e;
        for (cnt = 1; cnt <= LATENCY + 100; cnt++) begin
            @(posedge sys_clk);
            #1;
            if (finished) break;
            if (inj_cycle != 0 && cnt == inj_cycle) begin
                start = 1'b1;
                p     = 32'd13;
                d     = 32'd3;
            end else if (inj_cycle != 0 && cnt == inj_cycle + 1) begin
                start = 1'b0;
            end
        end
        check({name, "_latency"}, 64'(cnt), 64'(LATENCY));
        if (exp_q.size() == 0) begin
            check({name, "_queue"}, 64'(0), 64'(1));
        end else begin
            e = exp_q.pop_front();
            check({name, "_isPrime"}, 64'(isPrime), 64'(e));
        end
    endtask

    initial begin
        vecs[0]  = '{32'd11, 32'd23,         1'b0};
        vecs[1]  = '{32'd11, 32'd7,          1'b1};
        vecs[2]  = '{32'd7,  32'd127,        1'b0};
        vecs[3]  = '{32'd67, 32'd193707721,  1'b0};
        vecs[4]  = '{32'd67, 32'd193707723,  1'b1};
        vecs[5]  = '{32'd11, 32'd1,          1'b0};
        vecs[6]  = '{32'd11, 32'd0,          1'b1};
        vecs[7]  = '{32'd0,  32'd5,          1'b0};
        vecs[8]  = '{32'd31, 32'd2147483647, 1'b0};
        vecs[9]  = '{32'd32, 32'hFFFFFFFF,   1'b0};
        vecs[10] = '{32'd5,  32'd2,          1'b1};
        vecs[11] = '{32'd0,  32'd2,          1'b0};

        #1;
        check("reset_finished", 64'(finished), 64'(0));
        check("reset_isPrime", 64'(isPrime), 64'(0));
        check("reset_state", 64'(state_dbg), 64'(IDLE));
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        check("idle_finished", 64'(finished), 64'(0));

        for (int k = 0; k < 12; k++) begin
            launch(vecs[k].p, vecs[k].d, vecs[k].exp);
            wait_done($sformatf("vec%0d", k), 0);
        end

        // Stray start while busy must be ignored.
        launch(32'd11, 32'd23, 1'b0);
        wait_done("busy_start", 100);

        // Result and finished hold in DONE.
        repeat (3) @(negedge sys_clk);
        check("hold_finished", 64'(finished), 64'(1));
        check("hold_isPrime", 64'(isPrime), 64'(0));

        for (int k = 0; k < 4; k++) begin
            logic [31:0] pv;
            logic [31:0] dv;
            pv = 32'($urandom_range(1, 200));
            dv = 2 * 32'($urandom_range(1, 1000)) * pv + 1;
            launch(pv, dv, model(pv, dv));
            wait_done($sformatf("rand%0d", k), 0);
        end

        // Leave isPrime=1, then abort a run mid-way with reset.
        launch(32'd11, 32'd7, 1'b1);
        wait_done("pre_reset", 0);
        launch(32'd67, 32'd193707723, 1'b1);
        repeat (499) @(posedge sys_clk);
        #2;
        sys_rst_n = 1'b0;
        #1;
        check("abort_finished", 64'(finished), 64'(0));
        check("abort_isPrime", 64'(isPrime), 64'(0));
        check("abort_state", 64'(state_dbg), 64'(IDLE));
        exp_q.delete();
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);
        check("post_reset_state", 64'(state_dbg), 64'(IDLE));
        launch(32'd11, 32'd23, 1'b0);
        wait_done("post_reset", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
